// File: rtl/txrx_mode_sequencer.sv
// txrx_mode_sequencer
//   Sequences the RF front-end between OFF, RX and TX. Power-up order is LO,
//   then T/R switch, then amplifier. Power-down order is the reverse, with a
//   break-before-make guard dwell between steps. Settle dwells are
//   programmable per request.
//
// Ports
//   wb_clk_i     clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  mode request valid
//   req_mode_i   requested mode: 00 OFF, 01 RX, 10 TX, 11 reserved (treated as OFF)
//   req_ready_o  request can be accepted (OFF or ACTIVE, kill_i low)
//   settle_i     settle dwell, sampled on accept (dwell = settle_i + 1 cycles)
//   kill_i       emergency off, level-sensitive
//   lo_en_o      LO/synth enable
//   sw_rx_o      T/R switch to RX path
//   sw_tx_o      T/R switch to TX path
//   lna_en_o     LNA enable
//   pa_en_o      PA enable
//   mode_o       settled mode
//   busy_o       transition in progress
//   done_o       one-cycle pulse when a request completes
//   err_o        one-cycle pulse on reserved request or kill rising edge

// Invariant checker for the front-end enables.
module txrx_mode_sequencer_chk (
  input logic clk,
  input logic rst_n,
  input logic lo_en,
  input logic sw_rx,
  input logic sw_tx,
  input logic lna_en,
  input logic pa_en
);

  a_sw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(sw_rx && sw_tx));
  a_pa_tx:   assert property (@(posedge clk) disable iff (!rst_n) !(pa_en && !sw_tx));
  a_lna_rx:  assert property (@(posedge clk) disable iff (!rst_n) !(lna_en && !sw_rx));
  a_amp_lo:  assert property (@(posedge clk) disable iff (!rst_n) !((pa_en || lna_en) && !lo_en));

endmodule

module txrx_mode_sequencer #(
  parameter int CNT_W = 8,
  parameter int GUARD = 4
) (
  input  logic             wb_clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  input  logic [1:0]       req_mode_i,
  output logic             req_ready_o,
  input  logic [CNT_W-1:0] settle_i,
  input  logic             kill_i,
  output logic             lo_en_o,
  output logic             sw_rx_o,
  output logic             sw_tx_o,
  output logic             lna_en_o,
  output logic             pa_en_o,
  output logic [1:0]       mode_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_LO_UP  = 3'd1,
    ST_SW_SET = 3'd2,
    ST_AMP_UP = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_AMP_DN = 3'd5,
    ST_SW_CLR = 3'd6,
    ST_LO_DN  = 3'd7
  } state_t;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_RX  = 2'b01;
  localparam logic [1:0] MODE_TX  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Counter is loaded with dwell-1, so GUARD up to 2^CNT_W still fits.
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] settle_r, settle_s;
  logic [1:0]       tgt_r, tgt_s;
  logic             kill_d_r;

  logic             ready_r, ready_s;
  logic             lo_en_r, lo_en_s;
  logic             sw_rx_r, sw_rx_s;
  logic             sw_tx_r, sw_tx_s;
  logic             lna_en_r, lna_en_s;
  logic             pa_en_r, pa_en_s;
  logic [1:0]       mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             err_r, err_s;

  logic             accept_s;
  logic             cnt_zero_s;
  logic [1:0]       req_tgt_s;
  logic             reserved_s;

  // Request decode; kill_i gates acceptance directly so a request can never
  // slip in on the cycle kill_i rises (req_ready_o lags by one register).
  always_comb begin
    accept_s   = req_valid_i & ready_r & ~kill_i;
    reserved_s = (req_mode_i == MODE_RSV);
    req_tgt_s  = reserved_s ? MODE_OFF : req_mode_i;
    cnt_zero_s = (cnt_r == CNT_ZERO);
  end

  // State register and all registered outputs.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_OFF;
      cnt_r    <= CNT_ZERO;
      settle_r <= CNT_ZERO;
      tgt_r    <= MODE_OFF;
      kill_d_r <= 1'b0;
      ready_r  <= 1'b0;
      lo_en_r  <= 1'b0;
      sw_rx_r  <= 1'b0;
      sw_tx_r  <= 1'b0;
      lna_en_r <= 1'b0;
      pa_en_r  <= 1'b0;
      mode_r   <= MODE_OFF;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      settle_r <= settle_s;
      tgt_r    <= tgt_s;
      kill_d_r <= kill_i;
      ready_r  <= ready_s;
      lo_en_r  <= lo_en_s;
      sw_rx_r  <= sw_rx_s;
      sw_tx_r  <= sw_tx_s;
      lna_en_r <= lna_en_s;
      pa_en_r  <= pa_en_s;
      mode_r   <= mode_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      err_r    <= err_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    settle_s = settle_r;
    tgt_s    = tgt_r;
    lo_en_s  = lo_en_r;
    sw_rx_s  = sw_rx_r;
    sw_tx_s  = sw_tx_r;
    lna_en_s = lna_en_r;
    pa_en_s  = pa_en_r;
    mode_s   = mode_r;
    done_s   = 1'b0;
    err_s    = kill_i & ~kill_d_r;

    if (kill_i) begin
      state_s  = ST_OFF;
      cnt_s    = CNT_ZERO;
      tgt_s    = MODE_OFF;
      lo_en_s  = 1'b0;
      sw_rx_s  = 1'b0;
      sw_tx_s  = 1'b0;
      lna_en_s = 1'b0;
      pa_en_s  = 1'b0;
      mode_s   = MODE_OFF;
    end else begin
      case (state_r)
        ST_OFF: begin
          if (accept_s) begin
            tgt_s    = req_tgt_s;
            settle_s = settle_i;
            err_s    = reserved_s;
            if (req_tgt_s == MODE_OFF) begin
              done_s = 1'b1;
            end else begin
              state_s = ST_LO_UP;
              lo_en_s = 1'b1;
              cnt_s   = settle_i;
            end
          end else begin
            state_s = ST_OFF;
          end
        end
        ST_LO_UP: begin
          if (cnt_zero_s) begin
            state_s = ST_SW_SET;
            sw_rx_s = (tgt_r == MODE_RX);
            sw_tx_s = (tgt_r == MODE_TX);
            cnt_s   = GUARD_LOAD;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_SW_SET: begin
          if (cnt_zero_s) begin
            state_s  = ST_AMP_UP;
            lna_en_s = (tgt_r == MODE_RX);
            pa_en_s  = (tgt_r == MODE_TX);
            cnt_s    = settle_r;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_AMP_UP: begin
          if (cnt_zero_s) begin
            state_s = ST_ACTIVE;
            mode_s  = tgt_r;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_ACTIVE: begin
          if (accept_s) begin
            tgt_s    = req_tgt_s;
            settle_s = settle_i;
            err_s    = reserved_s;
            if (req_tgt_s == mode_r) begin
              done_s = 1'b1;
            end else begin
              // Amps drop first; the settled mode is no longer valid.
              state_s  = ST_AMP_DN;
              lna_en_s = 1'b0;
              pa_en_s  = 1'b0;
              mode_s   = MODE_OFF;
              cnt_s    = GUARD_LOAD;
            end
          end else begin
            state_s = ST_ACTIVE;
          end
        end
        ST_AMP_DN: begin
          if (cnt_zero_s) begin
            state_s = ST_SW_CLR;
            sw_rx_s = 1'b0;
            sw_tx_s = 1'b0;
            cnt_s   = GUARD_LOAD;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_SW_CLR: begin
          if (cnt_zero_s) begin
            if (tgt_r == MODE_OFF) begin
              state_s = ST_LO_DN;
              lo_en_s = 1'b0;
              cnt_s   = CNT_ZERO;
            end else begin
              // Mode swap: LO stays up, go straight to the new switch path.
              state_s = ST_SW_SET;
              sw_rx_s = (tgt_r == MODE_RX);
              sw_tx_s = (tgt_r == MODE_TX);
              cnt_s   = GUARD_LOAD;
            end
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_LO_DN: begin
          if (cnt_zero_s) begin
            state_s = ST_OFF;
            mode_s  = MODE_OFF;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_s  = ST_OFF;
          cnt_s    = CNT_ZERO;
          tgt_s    = MODE_OFF;
          lo_en_s  = 1'b0;
          sw_rx_s  = 1'b0;
          sw_tx_s  = 1'b0;
          lna_en_s = 1'b0;
          pa_en_s  = 1'b0;
          mode_s   = MODE_OFF;
        end
      endcase
    end

    ready_s = ~kill_i & ((state_s == ST_OFF) | (state_s == ST_ACTIVE));
    busy_s  = ~((state_s == ST_OFF) | (state_s == ST_ACTIVE));
  end

  assign req_ready_o = ready_r;
  assign lo_en_o     = lo_en_r;
  assign sw_rx_o     = sw_rx_r;
  assign sw_tx_o     = sw_tx_r;
  assign lna_en_o    = lna_en_r;
  assign pa_en_o     = pa_en_r;
  assign mode_o      = mode_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign err_o       = err_r;

  txrx_mode_sequencer_chk u_chk (
    .clk    (wb_clk_i),
    .rst_n  (rst_ni),
    .lo_en  (lo_en_r),
    .sw_rx  (sw_rx_r),
    .sw_tx  (sw_tx_r),
    .lna_en (lna_en_r),
    .pa_en  (pa_en_r)
  );

endmodule

// File: tb/tb_txrx_mode_sequencer.sv
// Self-checking bench for txrx_mode_sequencer. Expected output vectors are
// pushed to a scoreboard, keyed by cycle, when each request is driven, and
// are popped and compared on the falling edge of that cycle.
// Vector layout: {ready, lo, sw_rx, sw_tx, lna, pa, mode[1:0], busy, done, err}
module tb_txrx_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       req_valid;
  logic [1:0] req_mode;
  logic [7:0] settle;
  logic       kill;
  logic       req_ready, lo_en, sw_rx, sw_tx, lna_en, pa_en, busy, done, err;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base    = 0;

  int         sb_cyc[$];
  string      sb_tag[$];
  logic [10:0] sb_exp[$];

  logic [10:0] obs;
  assign obs = {req_ready, lo_en, sw_rx, sw_tx, lna_en, pa_en, mode, busy, done, err};

  txrx_mode_sequencer #(.CNT_W(8), .GUARD(4)) dut (
    .wb_clk_i    (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_mode_i  (req_mode),
    .req_ready_o (req_ready),
    .settle_i    (settle),
    .kill_i      (kill),
    .lo_en_o     (lo_en),
    .sw_rx_o     (sw_rx),
    .sw_tx_o     (sw_tx),
    .lna_en_o    (lna_en),
    .pa_en_o     (pa_en),
    .mode_o      (mode),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [10:0] ev(input logic rdy, input logic lo, input logic rx,
                                     input logic tx, input logic lna, input logic pa,
                                     input logic [1:0] md, input logic bsy,
                                     input logic dn, input logic er);
    return {rdy, lo, rx, tx, lna, pa, md, bsy, dn, er};
  endfunction

  task automatic exp_at(input int off, input string tag, input logic [10:0] v);
    sb_cyc.push_back(base + off);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic start_req(input logic [1:0] m, input logic [7:0] s);
    req_valid = 1'b1;
    req_mode  = m;
    settle    = s;
    base      = cyc;
  endtask

  // Scoreboard pop/compare plus per-cycle front-end invariants.
  always @(negedge clk) begin
    while (sb_cyc.size() > 0 && sb_cyc[0] <= cyc) begin
      check_val(sb_tag[0], {21'd0, obs}, {21'd0, sb_exp[0]});
      void'(sb_cyc.pop_front());
      void'(sb_tag.pop_front());
      void'(sb_exp.pop_front());
    end
    if (rst_ni) begin
      check_val("invariant",
                {31'd0, (sw_rx & sw_tx) | (pa_en & ~sw_tx) | (lna_en & ~sw_rx) |
                        ((pa_en | lna_en) & ~lo_en)}, 32'd0);
    end
  end

  initial begin
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    req_mode  = 2'b00;
    settle    = 8'd0;
    kill      = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_outs", {21'd0, obs}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check_val("idle_ready", {21'd0, obs}, {21'd0, ev(1,0,0,0,0,0,2'd0,0,0,0)});

    // OFF -> RX, settle 3
    start_req(2'b01, 8'd3);
    exp_at(1,  "rx_lo_up",  ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(4,  "rx_lo_end", ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(5,  "rx_sw",     ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(8,  "rx_sw_end", ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(9,  "rx_lna",    ev(0,1,1,0,1,0,2'd0,1,0,0));
    exp_at(12, "rx_lna_end",ev(0,1,1,0,1,0,2'd0,1,0,0));
    exp_at(13, "rx_active", ev(1,1,1,0,1,0,2'd1,0,1,0));
    exp_at(14, "rx_hold",   ev(1,1,1,0,1,0,2'd1,0,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (14) @(negedge clk);

    // RX -> TX, settle 0
    start_req(2'b10, 8'd0);
    exp_at(1,  "tx_amp_dn", ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(4,  "tx_amp_dn4",ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(5,  "tx_sw_clr", ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(8,  "tx_sw_clr4",ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(9,  "tx_sw_set", ev(0,1,0,1,0,0,2'd0,1,0,0));
    exp_at(12, "tx_sw_set4",ev(0,1,0,1,0,0,2'd0,1,0,0));
    exp_at(13, "tx_pa",     ev(0,1,0,1,0,1,2'd0,1,0,0));
    exp_at(14, "tx_active", ev(1,1,0,1,0,1,2'd2,0,1,0));
    exp_at(15, "tx_hold",   ev(1,1,0,1,0,1,2'd2,0,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (15) @(negedge clk);

    // TX -> OFF
    start_req(2'b00, 8'd5);
    exp_at(1,  "off_pa_dn", ev(0,1,0,1,0,0,2'd0,1,0,0));
    exp_at(4,  "off_pa_dn4",ev(0,1,0,1,0,0,2'd0,1,0,0));
    exp_at(5,  "off_sw_clr",ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(8,  "off_sw_clr4",ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(9,  "off_lo_dn", ev(0,0,0,0,0,0,2'd0,1,0,0));
    exp_at(10, "off_done",  ev(1,0,0,0,0,0,2'd0,0,1,0));
    exp_at(11, "off_idle",  ev(1,0,0,0,0,0,2'd0,0,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (11) @(negedge clk);

    // Reserved request from OFF
    start_req(2'b11, 8'd7);
    exp_at(1, "rsv_pulse", ev(1,0,0,0,0,0,2'd0,0,1,1));
    exp_at(2, "rsv_after", ev(1,0,0,0,0,0,2'd0,0,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // OFF -> RX with settle 0 (one-cycle settle dwells)
    start_req(2'b01, 8'd0);
    exp_at(1, "rx0_lo",     ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(2, "rx0_sw",     ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(5, "rx0_sw4",    ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(6, "rx0_lna",    ev(0,1,1,0,1,0,2'd0,1,0,0));
    exp_at(7, "rx0_active", ev(1,1,1,0,1,0,2'd1,0,1,0));
    exp_at(8, "rx0_hold",   ev(1,1,1,0,1,0,2'd1,0,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Same-mode request while RX
    start_req(2'b01, 8'd9);
    exp_at(1, "same_done",  ev(1,1,1,0,1,0,2'd1,0,1,0));
    exp_at(2, "same_hold",  ev(1,1,1,0,1,0,2'd1,0,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // RX -> TX with settle 10, kill during AMP_UP
    start_req(2'b10, 8'd10);
    exp_at(13, "k_amp_up",  ev(0,1,0,1,0,1,2'd0,1,0,0));
    exp_at(15, "k_amp_up3", ev(0,1,0,1,0,1,2'd0,1,0,0));
    exp_at(16, "k_off",     ev(0,0,0,0,0,0,2'd0,0,0,1));
    exp_at(17, "k_held",    ev(0,0,0,0,0,0,2'd0,0,0,0));
    exp_at(20, "k_held_req",ev(0,0,0,0,0,0,2'd0,0,0,0));
    exp_at(21, "k_release", ev(1,0,0,0,0,0,2'd0,0,0,0));
    exp_at(22, "k_no_done", ev(1,0,0,0,0,0,2'd0,0,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (14) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = 2'b01;
    repeat (4) @(negedge clk);
    kill      = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset during SW_SET
    start_req(2'b01, 8'd2);
    exp_at(1, "ar_lo",  ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(4, "ar_sw",  ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(5, "ar_sw2", ev(0,1,1,0,0,0,2'd0,1,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 check_val("async_rst", {21'd0, obs}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // OFF -> RX with settle 255 (256-cycle dwells)
    start_req(2'b01, 8'd255);
    exp_at(1,   "big_lo",     ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(256, "big_lo_end", ev(0,1,0,0,0,0,2'd0,1,0,0));
    exp_at(257, "big_sw",     ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(260, "big_sw_end", ev(0,1,1,0,0,0,2'd0,1,0,0));
    exp_at(261, "big_lna",    ev(0,1,1,0,1,0,2'd0,1,0,0));
    exp_at(516, "big_lna_end",ev(0,1,1,0,1,0,2'd0,1,0,0));
    exp_at(517, "big_active", ev(1,1,1,0,1,0,2'd1,0,1,0));
    exp_at(518, "big_hold",   ev(1,1,1,0,1,0,2'd1,0,0,0));
    @(negedge clk); req_valid = 1'b0;
    repeat (520) @(negedge clk);

    check_val("sb_drained", sb_cyc.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
